// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// One access is in flight at a time, and every access takes a fixed three
// cycles: IDLE sample, ACCESS, DONE ack. Requests are sampled only in IDLE.

// Per-port response stage: the one-cycle ack pulse and the read-data register.
module dmem_arb_port #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          done_i,     // this port's access completes at this edge
    input  logic          rd_i,       // the completing access is a read
    input  logic [DW-1:0] rd_data_i,  // memory read data
    output logic          ack_o,
    output logic [DW-1:0] rdata_o
);

    logic          ack_q;
    logic [DW-1:0] rdata_q;

    // Ack is high for the single cycle after ACCESS; read data is captured on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= done_i;
            if (done_i && rd_i)
                rdata_q <= rd_data_i;
        end
    end

    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;

endmodule

module dmem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_A,
    output logic [DW-1:0] mem_WD,
    output logic          mem_WE,
    input  logic [DW-1:0] mem_RD,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        state_q;
    logic          lg_q;        // port granted last; the other port wins a tie
    logic          win_q;       // port owning the access in flight
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          mem_we_q;
    logic          busy_q;

    logic          win_d;
    logic          we_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;

    logic [1:0]    done_w;
    logic [1:0]    ack_w;
    logic [1:0][DW-1:0] rdata_w;

    // Round-robin pick: a lone requester always wins, a tie goes to the port not granted last
    always_comb begin
        win_d = 1'b0;
        if (req0 && req1)
            win_d = ~lg_q;
        else if (req1)
            win_d = 1'b1;
        we_d    = win_d ? we1    : we0;
        addr_d  = win_d ? addr1  : addr0;
        wdata_d = win_d ? wdata1 : wdata0;
    end

    // Main FSM: latch the winner in IDLE, drive memory in ACCESS, return from DONE unconditionally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lg_q     <= 1'b1;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        win_q    <= win_d;
                        lg_q     <= win_d;
                        we_q     <= we_d;
                        addr_q   <= addr_d;
                        wdata_q  <= wdata_d;
                        mem_we_q <= we_d;
                        busy_q   <= 1'b1;
                        state_q  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_we_q <= 1'b0;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    // Response stage per port; only the winner sees the completion strobe
    for (genvar i = 0; i < 2; i++) begin : g_port
        assign done_w[i] = (state_q == S_ACCESS) && (win_q == 1'(i));

        dmem_arb_port #(.DW(DW)) u_port (
            .clk       (clk),
            .rst       (rst),
            .done_i    (done_w[i]),
            .rd_i      (~we_q),
            .rd_data_i (mem_RD),
            .ack_o     (ack_w[i]),
            .rdata_o   (rdata_w[i])
        );
    end

    assign ack0   = ack_w[0];
    assign ack1   = ack_w[1];
    assign rdata0 = rdata_w[0];
    assign rdata1 = rdata_w[1];

    // Latched request fields keep driving the memory outside ACCESS; only the write enable is gated
    assign mem_A  = addr_q;
    assign mem_WD = wdata_q;
    assign mem_WE = mem_we_q;
    assign busy   = busy_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 10, address width of both requester ports and the memory port.
REQ-002 Parameter DW, default 32, data width of both requester ports and the memory port.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset. It SHALL expose the following ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active high.
- req0/req1  in  1 each  access request from port 0 / port 1.
- we0/we1  in  1 each  1 = write, 0 = read.
- addr0/addr1  in  AW each  word address.
- wdata0/wdata1  in  DW each  write data.
- ack0/ack1  out  1 each  one-cycle completion pulse.
- rdata0/rdata1  out  DW each  registered read data.
- mem_A  out  AW  address to the data memory.
- mem_WD  out  DW  write data to the data memory.
- mem_WE  out  1  write enable to the data memory.
- mem_RD  in  DW  combinational read data from the data memory.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-004 FSM states SHALL be IDLE, ACCESS and DONE. State, latched request fields and outputs SHALL all be registered.
REQ-005 In IDLE, when at least one reqN is sampled high at a rising edge, the arbiter SHALL latch the winner's index, we, addr and wdata, then move to ACCESS.
REQ-006 In IDLE with no request, the state SHALL remain IDLE and the latched fields SHALL hold.
REQ-007 Arbitration SHALL be round-robin via a one-bit last-grant pointer lg.
- If both requests are high, the port != lg wins.
- If one request is high, that port wins regardless of lg.
- lg SHALL update to the winner on entry to ACCESS.
REQ-008 In ACCESS:
- mem_A SHALL equal the latched addr.
- mem_WD SHALL equal the latched wdata.
- mem_WE SHALL equal the latched we.
REQ-009 Outside ACCESS, mem_WE SHALL be 0. mem_A and mem_WD SHALL continue to present the latched values.
REQ-010 At the rising edge that ends ACCESS:
- If the latched we = 0, mem_RD SHALL be captured into rdataN of the winner.
- If the latched we = 1, rdataN SHALL hold its previous value.
- The state SHALL move to DONE.
REQ-011 In DONE, ackN of the winner SHALL be 1 for exactly that cycle and the other ack SHALL be 0.
REQ-012 In DONE, requests SHALL be ignored, and the state SHALL return to IDLE unconditionally.
REQ-013 Latency SHALL be fixed: request sampled at edge k, memory access in cycle k+1, ack high in cycle k+2, next grant possible at edge k+3.
REQ-014 A requester SHALL hold reqN, weN, addrN and wdataN stable until it sees ackN. The arbiter samples these only in IDLE.
REQ-015 A requester that keeps reqN high after ack SHALL be treated as a new request at the next IDLE sample, subject to round-robin.
REQ-016 Addresses SHALL pass through unmodified, all AW bits. No range check is performed, and out-of-range behaviour is the memory's.
REQ-017 ack0 and ack1 SHALL never be high in the same cycle. At most one memory access SHALL be in flight.
REQ-018 busy SHALL be 1 in ACCESS and DONE, and 0 in IDLE.

Reset
REQ-019 Asserting rst SHALL immediately, without waiting for clk, force:
- state = IDLE and lg = 1, so that port 0 wins the first tie;
- ack0 = ack1 = 0;
- rdata0 = rdata1 = 0;
- latched addr, wdata and we = 0;
- mem_WE = 0 and busy = 0.
REQ-020 Reset asserted during ACCESS SHALL abort the access. No write SHALL occur after rst rises, and no ack SHALL be issued for the aborted request.
REQ-021 After rst falls, the first request SHALL be sampled at the first rising edge with rst low.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single write, port 0: req0=1, we0=1, addr0=5, wdata0=0xDEADBEEF -> mem_WE=1 with mem_A=5 for one cycle; ack0 pulses 2 cycles after the sampling edge; ack1=0 throughout.
- Read back, port 1: memory model holds 0xDEADBEEF at word 5; req1=1, we1=0, addr1=5 -> mem_WE stays 0; rdata1=0xDEADBEEF when ack1=1; rdata0 unchanged.
- Tie after reset: req0 and req1 both held high -> grant order 0, 1, 0, 1; each ack spaced 3 cycles apart; no double service.
- Tie with lg=0: port 0 served last, then both request -> port 1 served first.
- Reset mid-ACCESS: write to addr 7, rst pulsed high during ACCESS -> mem_WE drops immediately; word 7 unchanged; ack0 never pulses; rdata0=rdata1=0; busy=0.
- Back-to-back single requester: req0 held high for 4 accesses to addrs 1..4 -> 4 ack0 pulses, 3 cycles apart; busy low exactly one cycle between accesses.
